pipeline_reg_chain: RTL and testbench

Parametrised chain of pipeline registers with per-stage valid bits, stall (hold), flush (kill) and selectable lockstep or bubble-collapsing advance. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers into one configurable block that the pipelined MIPS datapath instantiates between stages. The hazard unit drives its stall/flush vectors, and the datapath packs per-stage control and data fields into its payload.

---
 rtl/pipeline_pkg.sv | 8 +
 rtl/pipe_stage_cell.sv | 51 +++++
 rtl/pipeline_reg_chain.sv | 100 ++++++++++
 tb/tb_pipeline_reg_chain.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the configurable pipeline register chain.
package pipeline_pkg;

  // Advance modes selected by the COLLAPSE parameter of pipeline_reg_chain.
  localparam int PL_LOCKSTEP = 0;
  localparam int PL_COLLAPSE = 1;

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: valid bit and payload register with flush > hold > load priority.
module pipe_stage_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  valid,
  output logic                  next_valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  next_valid_s;

  // Next valid bit: flush kills the stage whether it loads or holds.
  always_comb begin
    next_valid_s = 1'b0;
    if (flush) begin
      next_valid_s = 1'b0;
    end else if (hold) begin
      next_valid_s = valid_r;
    end else begin
      next_valid_s = src_valid;
    end
  end

  // Stage registers: valid follows the priority above, payload loads unless held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_r <= next_valid_s;
      if (hold) begin
        data_r <= data_r;
      end else begin
        data_r <= src_data;
      end
    end
  end

  assign valid      = valid_r;
  assign next_valid = next_valid_s;
  assign data       = data_r;

endmodule

// File: rtl/pipeline_reg_chain.sv
// Chain of STAGES pipeline registers with stall, flush and lockstep or bubble-collapsing advance.
module pipeline_reg_chain
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 4,
  parameter int COLLAPSE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall,
  input  logic [STAGES-1:0]            flush,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*DATA_WIDTH-1:0] stage_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]            hold_s;
  logic [STAGES-1:0]            src_valid_s;
  logic [STAGES-1:0]            valid_s;
  logic [STAGES-1:0]            next_valid_s;
  logic [STAGES*DATA_WIDTH-1:0] src_data_s;
  logic [STAGES*DATA_WIDTH-1:0] data_s;
  logic [OCC_W-1:0]             occupancy_r;

  // Number of set bits in a stage valid vector.
  function automatic logic [OCC_W-1:0] count_ones(input logic [STAGES-1:0] bits);
    logic [OCC_W-1:0] n;
    n = {OCC_W{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      n = n + OCC_W'(bits[i]);
    end
    return n;
  endfunction

  // Hold chain from the output sink (never blocks) back toward stage 0.
  always_comb begin
    logic down_hold_s;
    down_hold_s = 1'b0;
    hold_s      = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (COLLAPSE == PL_COLLAPSE) begin
        // An empty stage never holds, so a bubble absorbs upstream data.
        down_hold_s = valid_s[i] & (stall[i] | down_hold_s);
      end else begin
        down_hold_s = stall[i] | down_hold_s;
      end
      hold_s[i] = down_hold_s;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign src_valid_s[i]                            = in_valid;
      assign src_data_s[i*DATA_WIDTH +: DATA_WIDTH]    = in_data;
    end else begin : g_rest
      // A held upstream stage offers nothing, which inserts a bubble here.
      assign src_valid_s[i]                            = valid_s[i-1] & ~hold_s[i-1];
      assign src_data_s[i*DATA_WIDTH +: DATA_WIDTH]    = data_s[(i-1)*DATA_WIDTH +: DATA_WIDTH];
    end

    pipe_stage_cell #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_cell (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold_s[i]),
      .flush     (flush[i]),
      .src_valid (src_valid_s[i]),
      .src_data  (src_data_s[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid     (valid_s[i]),
      .next_valid(next_valid_s[i]),
      .data      (data_s[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Occupancy register tracks the population of the valid vector after this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy_r <= {OCC_W{1'b0}};
    end else begin
      occupancy_r <= count_ones(next_valid_s);
    end
  end

  assign in_ready    = ~hold_s[0];
  assign out_valid   = valid_s[STAGES-1] & ~stall[STAGES-1];
  assign out_data    = data_s[(STAGES-1)*DATA_WIDTH +: DATA_WIDTH];
  assign stage_valid = valid_s;
  assign stage_data  = data_s;
  assign occupancy   = occupancy_r;

endmodule

// File: tb/tb_pipeline_reg_chain.sv
// Directed bench for pipeline_reg_chain: one lockstep and one collapsing instance.
module tb_pipeline_reg_chain;

  localparam int DW = 32;
  localparam int ST = 4;
  localparam int OW = $clog2(ST + 1);

  logic clk;
  logic reset;

  logic          l_in_valid, l_in_ready, l_out_valid;
  logic [DW-1:0] l_in_data, l_out_data;
  logic [ST-1:0] l_stall, l_flush, l_stage_valid;
  logic [ST*DW-1:0] l_stage_data;
  logic [OW-1:0] l_occupancy;

  logic          c_in_valid, c_in_ready, c_out_valid;
  logic [DW-1:0] c_in_data, c_out_data;
  logic [ST-1:0] c_stall, c_flush, c_stage_valid;
  logic [ST*DW-1:0] c_stage_data;
  logic [OW-1:0] c_occupancy;

  int checks   = 0;
  int failures = 0;

  pipeline_reg_chain #(.DATA_WIDTH(DW), .STAGES(ST), .COLLAPSE(0)) dut_ls (
    .clk(clk), .reset(reset), .in_valid(l_in_valid), .in_data(l_in_data),
    .in_ready(l_in_ready), .stall(l_stall), .flush(l_flush),
    .out_valid(l_out_valid), .out_data(l_out_data), .stage_valid(l_stage_valid),
    .stage_data(l_stage_data), .occupancy(l_occupancy)
  );

  pipeline_reg_chain #(.DATA_WIDTH(DW), .STAGES(ST), .COLLAPSE(1)) dut_cl (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .stall(c_stall), .flush(c_flush),
    .out_valid(c_out_valid), .out_data(c_out_data), .stage_valid(c_stage_valid),
    .stage_data(c_stage_data), .occupancy(c_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_stall = '0; l_flush = '0;
    c_in_valid = 1'b0; c_in_data = '0; c_stall = '0; c_flush = '0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_flush = '0; l_stall = 4'b1111;
    c_in_valid = 1'b0; c_in_data = '0; c_flush = '0; c_stall = 4'b1111;
    tick();
    checks++; if (l_stage_valid !== 4'b0000) begin failures++; $display("FAIL rst_stage_valid got %b exp 0000", l_stage_valid); end
    checks++; if (l_occupancy !== 3'd0) begin failures++; $display("FAIL rst_occupancy got %0d exp 0", l_occupancy); end
    checks++; if (l_out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got %h exp 0", l_out_data); end
    checks++; if (l_in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_lockstep got %b exp 0", l_in_ready); end
    checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_collapse got %b exp 1", c_in_ready); end
    l_stall = '0; c_stall = '0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      l_in_valid = 1'b1;
      l_in_data  = 32'(i + 1);
      tick();
    end
    l_in_valid = 1'b0;
    #1;
    checks++; if (l_stage_valid !== 4'b0111) begin failures++; $display("FAIL fill_stage_valid got %b exp 0111", l_stage_valid); end
    checks++; if (l_occupancy !== 3'd3) begin failures++; $display("FAIL fill_occupancy got %0d exp 3", l_occupancy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (l_stage_valid !== 4'b0000) begin failures++; $display("FAIL async_stage_valid got %b exp 0000", l_stage_valid); end
    checks++; if (l_out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid got %b exp 0", l_out_valid); end
    checks++; if (l_occupancy !== 3'd0) begin failures++; $display("FAIL async_occupancy got %0d exp 0", l_occupancy); end
    checks++; if (l_stage_data !== 128'h0) begin failures++; $display("FAIL async_stage_data got %h exp 0", l_stage_data); end
    #1;
    reset = 1'b0;
    tick();
    checks++; if (l_stage_valid !== 4'b0000) begin failures++; $display("FAIL restart_empty got %b exp 0000", l_stage_valid); end
  endtask

  task automatic test_stream_lockstep;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      l_in_valid = (c < 8);
      l_in_data  = 32'(32'h10 + c);
      #1;
      checks++; if (l_in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready c=%0d got %b exp 1", c, l_in_ready); end
      checks++; if (l_out_valid !== (c >= 4)) begin failures++; $display("FAIL stream_out_valid c=%0d got %b exp %b", c, l_out_valid, (c >= 4)); end
      if (c >= 4) begin
        checks++; if (l_out_data !== 32'(32'h10 + c - 4)) begin failures++; $display("FAIL stream_out_data c=%0d got %h exp %h", c, l_out_data, 32'(32'h10 + c - 4)); end
      end
      tick();
    end
    l_in_valid = 1'b0;
  endtask

  task automatic test_load_use_stall;
    int exp_tab[14] = '{0, 0, 0, 0, 'h20, 'h21, 'h22, 0, 'h23, 'h24, 'h25, 'h26, 'h27, 0};
    int idx = 0;
    logic rdy_exp;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      l_in_valid = (idx < 8);
      l_in_data  = 32'(32'h20 + idx);
      l_stall    = (c == 5) ? 4'b0011 : 4'b0000;
      rdy_exp    = (c != 5);
      #1;
      checks++; if (l_in_ready !== rdy_exp) begin failures++; $display("FAIL loaduse_ready c=%0d got %b exp %b", c, l_in_ready, rdy_exp); end
      checks++; if (l_out_valid !== (exp_tab[c] != 0)) begin failures++; $display("FAIL loaduse_out_valid c=%0d got %b exp %b", c, l_out_valid, (exp_tab[c] != 0)); end
      if (exp_tab[c] != 0) begin
        checks++; if (l_out_data !== 32'(exp_tab[c])) begin failures++; $display("FAIL loaduse_out_data c=%0d got %h exp %h", c, l_out_data, exp_tab[c]); end
      end
      if (c == 6) begin
        checks++; if (l_stage_valid !== 4'b1011) begin failures++; $display("FAIL loaduse_bubble got %b exp 1011", l_stage_valid); end
      end
      tick();
      if (l_in_valid && rdy_exp) idx++;
    end
    l_in_valid = 1'b0;
    l_stall    = '0;
  endtask

  task automatic test_collapse;
    logic [DW-1:0] bd[4] = '{32'hC, 32'h0, 32'hA, 32'hB};
    logic          bv[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      c_in_valid = bv[c];
      c_in_data  = bd[c];
      tick();
    end
    c_in_valid = 1'b1; c_in_data = 32'hD; c_stall = 4'b1000;
    #1;
    checks++; if (c_stage_valid !== 4'b1011) begin failures++; $display("FAIL col_setup got %b exp 1011", c_stage_valid); end
    checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL col_ready_gap got %b exp 1", c_in_ready); end
    checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL col_out_stalled got %b exp 0", c_out_valid); end
    checks++; if (c_occupancy !== 3'd3) begin failures++; $display("FAIL col_occ3 got %0d exp 3", c_occupancy); end
    tick();
    c_in_data = 32'hE;
    #1;
    checks++; if (c_stage_valid !== 4'b1111) begin failures++; $display("FAIL col_full got %b exp 1111", c_stage_valid); end
    checks++; if (c_stage_data[2*DW +: DW] !== 32'hA) begin failures++; $display("FAIL col_a_in_gap got %h exp a", c_stage_data[2*DW +: DW]); end
    checks++; if (c_occupancy !== 3'd4) begin failures++; $display("FAIL col_occ4 got %0d exp 4", c_occupancy); end
    checks++; if (c_in_ready !== 1'b0) begin failures++; $display("FAIL col_ready_full got %b exp 0", c_in_ready); end
    tick();
    #1;
    checks++; if (c_in_ready !== 1'b0) begin failures++; $display("FAIL col_ready_full2 got %b exp 0", c_in_ready); end
    tick();
    c_stall = 4'b0000;
    #1;
    checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL col_ready_release got %b exp 1", c_in_ready); end
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 32'hC) begin failures++; $display("FAIL col_out_c got %b/%h exp 1/c", c_out_valid, c_out_data); end
    tick();
    c_in_valid = 1'b0;
    #1;
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 32'hA) begin failures++; $display("FAIL col_out_a got %b/%h exp 1/a", c_out_valid, c_out_data); end
    tick();
  endtask

  task automatic test_flush;
    int exp_tab[10] = '{0, 0, 0, 0, 0, 0, 'h32, 'h33, 0, 0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      l_in_valid = (c < 4);
      l_in_data  = 32'(32'h30 + c);
      l_flush    = (c == 1) ? 4'b0011 : 4'b0000;
      #1;
      if (c == 2) begin
        checks++; if (l_occupancy !== 3'd0) begin failures++; $display("FAIL flush_occ got %0d exp 0", l_occupancy); end
      end
      checks++; if (l_out_valid !== (exp_tab[c] != 0)) begin failures++; $display("FAIL flush_out_valid c=%0d got %b exp %b", c, l_out_valid, (exp_tab[c] != 0)); end
      if (exp_tab[c] != 0) begin
        checks++; if (l_out_data !== 32'(exp_tab[c])) begin failures++; $display("FAIL flush_out_data c=%0d got %h exp %h", c, l_out_data, exp_tab[c]); end
      end
      tick();
    end
    l_in_valid = 1'b0;
    l_flush    = '0;
  endtask

  task automatic test_flush_stall;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      l_in_valid = 1'b1;
      l_in_data  = 32'(32'h40 + c);
      tick();
    end
    l_in_data = 32'h44; l_stall = 4'b1000; l_flush = 4'b1000;
    #1;
    checks++; if (l_in_ready !== 1'b0) begin failures++; $display("FAIL fs_ready got %b exp 0", l_in_ready); end
    checks++; if (l_out_valid !== 1'b0) begin failures++; $display("FAIL fs_out_valid got %b exp 0", l_out_valid); end
    tick();
    l_stall = 4'b0000; l_flush = 4'b0000;
    #1;
    checks++; if (l_stage_valid !== 4'b0111) begin failures++; $display("FAIL fs_dropped got %b exp 0111", l_stage_valid); end
    checks++; if (l_out_valid !== 1'b0) begin failures++; $display("FAIL fs_out_after got %b exp 0", l_out_valid); end
    checks++; if (l_stage_data[2*DW +: DW] !== 32'h41 || l_stage_data[0 +: DW] !== 32'h43) begin failures++; $display("FAIL fs_frozen got %h/%h exp 41/43", l_stage_data[2*DW +: DW], l_stage_data[0 +: DW]); end
    checks++; if (l_occupancy !== 3'd3) begin failures++; $display("FAIL fs_occ got %0d exp 3", l_occupancy); end
    tick();
    l_in_valid = 1'b0;
    #1;
    checks++; if (l_out_valid !== 1'b1 || l_out_data !== 32'h41) begin failures++; $display("FAIL fs_resume got %b/%h exp 1/41", l_out_valid, l_out_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream_lockstep();
    test_load_use_stall();
    test_collapse();
    test_flush();
    test_flush_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
